// File: rtl/id_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue descriptor and sources in, stall/forward selects out.
// Latency: pure wiring, no storage.
// Backpressure: stall travels slave->master in the same cycle as the issue fields.
interface id_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) ();
  logic              issue_valid;
  logic              issue_writes;
  logic [ADDR_W-1:0] issue_dest;
  logic              issue_is_load;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic              src_a_used;
  logic              src_b_used;
  logic              flush;
  logic              stall;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              busy;

  // Decode stage drives the instruction and consumes the hazard verdict
  modport master (
    output issue_valid, issue_writes, issue_dest, issue_is_load,
    output src_a, src_b, src_a_used, src_b_used, flush,
    input  stall, fwd_sel_a, fwd_sel_b, busy
  );

  // Scoreboard samples the instruction and produces the hazard verdict
  modport slave (
    input  issue_valid, issue_writes, issue_dest, issue_is_load,
    input  src_a, src_b, src_a_used, src_b_used, flush,
    output stall, fwd_sel_a, fwd_sel_b, busy
  );
endinterface

// File: rtl/id_scoreboard.sv
// In-order pipeline scoreboard: tracks writers in EX..WB, picks forward sources, stalls load-use.
// Latency: stall/fwd_sel/busy are combinational from current inputs and entry state.
// Backpressure: stall=1 holds decode and inserts a bubble into entry 1.
// Optional macro ID_SCOREBOARD_PERF_EN adds perf_clear input and 32-bit stall_cycles counter.
module id_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int ADDR_W     = 5,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2
) (
  input  logic          clock,
  input  logic          reset,
  id_scoreboard_if.slave sb
`ifdef ID_SCOREBOARD_PERF_EN
  ,
  input  logic          perf_clear,
  output logic [31:0]   stall_cycles
`endif
);

  // Entry k (1..DEPTH) describes the instruction k stages past decode
  logic [DEPTH:1]    ent_valid;
  logic [DEPTH:1]    ent_load;
  logic [ADDR_W-1:0] ent_dest [1:DEPTH];

  logic [DEPTH:1]    ent_rdy;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              blk_a;
  logic              blk_b;
  logic              stall_int;
  logic              accept;

  // A load's result only exists once it reaches LOAD_READY; ALU results are ready from EX
  for (genvar k = 1; k <= DEPTH; k++) begin : g_rdy
    assign ent_rdy[k] = !ent_load[k] || (k >= LOAD_READY);
  end

  // Scan oldest to youngest so the youngest matching writer overrides older ones
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    blk_a = 1'b0;
    blk_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ent_valid[k] && sb.src_a_used && (sb.src_a != '0) && (ent_dest[k] == sb.src_a)) begin
        sel_a = ent_rdy[k] ? SEL_W'(k) : '0;
        blk_a = !ent_rdy[k];
      end
      if (ent_valid[k] && sb.src_b_used && (sb.src_b != '0) && (ent_dest[k] == sb.src_b)) begin
        sel_b = ent_rdy[k] ? SEL_W'(k) : '0;
        blk_b = !ent_rdy[k];
      end
    end
  end

  assign stall_int    = sb.issue_valid && (blk_a || blk_b);
  assign accept       = sb.issue_valid && sb.issue_writes && (sb.issue_dest != '0) && !stall_int;
  assign sb.stall     = stall_int;
  assign sb.fwd_sel_a = sel_a;
  assign sb.fwd_sel_b = sel_b;
  assign sb.busy      = |ent_valid;

  // Valid bits advance one stage per cycle; reset/flush wipe everything including the new entry
  always_ff @(posedge clock) begin
    if (reset || sb.flush) begin
      ent_valid <= '0;
    end else begin
      ent_valid <= {ent_valid[DEPTH-1:1], accept};
    end
  end

  // Payload shifts unconditionally; it is only ever qualified by the valid bits
  always_ff @(posedge clock) begin
    ent_dest[1] <= sb.issue_dest;
    ent_load    <= {ent_load[DEPTH-1:1], sb.issue_is_load};
    for (int k = 2; k <= DEPTH; k++) begin
      ent_dest[k] <= ent_dest[k-1];
    end
  end

`ifdef ID_SCOREBOARD_PERF_EN
  // Saturating count of stalled cycles; clearing takes priority over counting
  always_ff @(posedge clock) begin
    if (reset || perf_clear) begin
      stall_cycles <= '0;
    end else if (stall_int && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed hazard scenarios followed by random traffic,
// all outputs compared every cycle with a history-based model of issued instructions.
module tb_id_scoreboard;
  localparam int DEPTH      = 3;
  localparam int ADDR_W     = 5;
  localparam int LOAD_READY = 2;
  localparam int SEL_W      = 2;
  localparam int MAXC       = 2048;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  id_scoreboard_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

`ifdef ID_SCOREBOARD_PERF_EN
  logic        perf_clear = 1'b0;
  logic [31:0] stall_cycles;
  logic [31:0] exp_cnt = '0;
`endif

  id_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) dut (
    .clock(clock),
    .reset(reset),
    .sb(bus)
`ifdef ID_SCOREBOARD_PERF_EN
    ,
    .perf_clear(perf_clear),
    .stall_cycles(stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // History of what was accepted into the pipe in each cycle
  bit              acc      [MAXC];
  logic [ADDR_W-1:0] acc_dest [MAXC];
  bit              acc_ld   [MAXC];
  int              cyc       = 0;
  int              last_kill = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Instruction accepted k cycles ago is in entry k unless a later flush/reset killed it
  function automatic bit live(input int k);
    int c;
    c = cyc - k;
    return (c > last_kill) && acc[c];
  endfunction

  function automatic void lookup(input logic [ADDR_W-1:0] s, input bit used,
                                 output int sel, output bit blk);
    int c;
    sel = 0;
    blk = 0;
    if (used && s != 0) begin
      for (int k = 1; k <= DEPTH; k++) begin
        c = cyc - k;
        if (live(k) && acc_dest[c] == s) begin
          if (!acc_ld[c] || k >= LOAD_READY) sel = k;
          else blk = 1;
          return;
        end
      end
    end
  endfunction

  function automatic void model(output int sa, output int sbv, output bit st, output bit bz);
    bit ba, bb;
    lookup(bus.src_a, bus.src_a_used, sa, ba);
    lookup(bus.src_b, bus.src_b_used, sbv, bb);
    st = bus.issue_valid && (ba || bb);
    bz = 0;
    for (int k = 1; k <= DEPTH; k++) if (live(k)) bz = 1;
  endfunction

  task automatic drv(input bit v, input bit w, input int d, input bit ld,
                     input int sa, input bit au, input int sbs, input bit bu,
                     input bit fl, input bit rs);
    bus.issue_valid   = v;
    bus.issue_writes  = w;
    bus.issue_dest    = ADDR_W'(d);
    bus.issue_is_load = ld;
    bus.src_a         = ADDR_W'(sa);
    bus.src_a_used    = au;
    bus.src_b         = ADDR_W'(sbs);
    bus.src_b_used    = bu;
    bus.flush         = fl;
    reset             = rs;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string tag);
    int sa, sbv;
    bit st, bz;
    #2;
    model(sa, sbv, st, bz);
    chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
    chk({tag, ".fwd_a"}, 32'(bus.fwd_sel_a), 32'(sa));
    chk({tag, ".fwd_b"}, 32'(bus.fwd_sel_b), 32'(sbv));
    chk({tag, ".busy"},  32'(bus.busy), 32'(bz));
`ifdef ID_SCOREBOARD_PERF_EN
    chk({tag, ".cnt"}, stall_cycles, exp_cnt);
`endif
  endtask

  // Commit this cycle's inputs to the history, then advance one clock
  task automatic tick();
    int sa, sbv;
    bit st, bz;
    model(sa, sbv, st, bz);
    acc[cyc]      = bus.issue_valid && bus.issue_writes && (bus.issue_dest != 0) && !st;
    acc_dest[cyc] = bus.issue_dest;
    acc_ld[cyc]   = bus.issue_is_load;
    if (bus.flush || reset) last_kill = cyc;
`ifdef ID_SCOREBOARD_PERF_EN
    if (reset || perf_clear) exp_cnt = 0;
    else if (st && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Idle after reset: everything quiet
    for (int i = 0; i < 4; i++) begin
      idle(); check("idle");
      chk("idle_stall", 32'(bus.stall), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      tick();
    end

    // ALU write r3 then consume it from EX, then from MEM
    drv(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); check("alu_iss"); tick();
    drv(1, 0, 0, 0, 3, 1, 0, 0, 0, 0); check("alu_u1");
    chk("alu_fwd1", 32'(bus.fwd_sel_a), 1);
    chk("alu_nostall", 32'(bus.stall), 0);
    tick();
    drv(1, 0, 0, 0, 3, 1, 0, 0, 0, 0); check("alu_u2");
    chk("alu_fwd2", 32'(bus.fwd_sel_a), 2);
    tick();
    for (int i = 0; i < 3; i++) begin idle(); check("drain"); tick(); end

    // Load r5 then immediate use on src_b: one stall, then forward from entry 2
    drv(1, 1, 5, 1, 0, 0, 0, 0, 0, 0); check("ld_iss"); tick();
    drv(1, 0, 0, 0, 0, 0, 5, 1, 0, 0); check("ld_u1");
    chk("ld_stall", 32'(bus.stall), 1);
    tick();
    drv(1, 0, 0, 0, 0, 0, 5, 1, 0, 0); check("ld_u2");
    chk("ld_fwd2", 32'(bus.fwd_sel_b), 2);
    chk("ld_nostall", 32'(bus.stall), 0);
    tick();
    for (int i = 0; i < 3; i++) begin idle(); check("drain"); tick(); end

    // Two writes to r7: the younger wins
    drv(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); check("r7a"); tick();
    drv(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); check("r7b"); tick();
    drv(1, 0, 0, 0, 7, 1, 0, 0, 0, 0); check("r7u");
    chk("youngest", 32'(bus.fwd_sel_a), 1);
    tick();
    // r0 is never tracked
    drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); check("r0w"); tick();
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); check("r0u");
    chk("r0_fwd", 32'(bus.fwd_sel_a), 0);
    chk("r0_stall", 32'(bus.stall), 0);
    tick();
    for (int i = 0; i < 3; i++) begin idle(); check("drain"); tick(); end

    // Flush while a load-use hazard sits in decode
    drv(1, 1, 4, 1, 0, 0, 0, 0, 0, 0); check("fl_iss"); tick();
    drv(1, 0, 0, 0, 4, 1, 0, 0, 1, 0); check("fl_cyc");
    chk("fl_stall_before", 32'(bus.stall), 1);
    tick();
    drv(1, 0, 0, 0, 4, 1, 0, 0, 0, 0); check("fl_after");
    chk("fl_stall", 32'(bus.stall), 0);
    chk("fl_busy", 32'(bus.busy), 0);
    chk("fl_fwd", 32'(bus.fwd_sel_a), 0);
    tick();

    // Reset in the middle of a stall drops it next cycle
    drv(1, 1, 9, 1, 0, 0, 0, 0, 0, 0); check("rs_iss"); tick();
    drv(1, 0, 0, 0, 9, 1, 0, 0, 0, 1); check("rs_cyc"); tick();
    drv(1, 0, 0, 0, 9, 1, 0, 0, 0, 0); check("rs_after");
    chk("rs_stall", 32'(bus.stall), 0);
    chk("rs_busy", 32'(bus.busy), 0);
    tick();

`ifdef ID_SCOREBOARD_PERF_EN
    idle(); perf_clear = 1'b1; tick(); perf_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 6, 1, 0, 0, 0, 0, 0, 0); check("pf_iss"); tick();
      drv(1, 0, 0, 0, 6, 1, 0, 0, 0, 0); check("pf_st"); tick();
      drv(1, 0, 0, 0, 6, 1, 0, 0, 0, 0); check("pf_go"); tick();
    end
    idle(); #2; chk("perf_three", stall_cycles, 3);
    drv(1, 1, 6, 1, 0, 0, 0, 0, 0, 0); check("pc_iss"); tick();
    drv(1, 0, 0, 0, 6, 1, 0, 0, 0, 0); perf_clear = 1'b1; check("pc_st"); tick();
    perf_clear = 1'b0; idle(); #2; chk("perf_clear", stall_cycles, 0);
    tick();
`endif

    // Random traffic over a small register window so hazards are frequent
    for (int i = 0; i < 500; i++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 7),
          $urandom_range(0, 9) < 3, $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0);
`ifdef ID_SCOREBOARD_PERF_EN
      perf_clear = $urandom_range(0, 49) == 0;
`endif
      check("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, number of in-flight stages tracked after decode (entry 1 = EX, entry DEPTH = WB); legal range 2..8.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter LOAD_READY, default 2, first entry index at which a load's result is forwardable; legal range 1..DEPTH.
REQ-004 Parameter SEL_W, default 2, width of forward selects; SHALL hold values 0..DEPTH.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 issue_valid  input  1  decode stage holds a valid instruction.
REQ-008 issue_writes  input  1  decoded instruction writes a register.
REQ-009 issue_dest  input  ADDR_W  destination register of decoded instruction.
REQ-010 issue_is_load  input  1  decoded instruction takes its result from memory.
REQ-011 src_a / src_b  input  ADDR_W each  source register addresses (rs, rt).
REQ-012 src_a_used / src_b_used  input  1 each  source actually read by decoded instruction.
REQ-013 flush  input  1  discard all in-flight entries (exception/redirect).
REQ-014 stall  output  1  hold PC and IF/ID register; insert bubble into EX.
REQ-015 fwd_sel_a / fwd_sel_b  output  SEL_W each  0 = register file, k = forward from entry k.
REQ-016 busy  output  1  any entry valid.

Function
REQ-017 State SHALL be DEPTH entries {valid, dest, is_load}; no other datapath storage.
REQ-018 Each cycle entry k+1 SHALL load entry k (k=1..DEPTH-1); entry DEPTH retires.
REQ-019 Entry 1 SHALL load {issue_valid & issue_writes & (issue_dest!=0) & ~stall, issue_dest, issue_is_load}; a stall inserts a bubble (valid=0).
REQ-020 For each used source s != 0, match = youngest (smallest k) valid entry with dest == s; older matches SHALL be ignored.
REQ-021 Entry k ready iff ~is_load or k >= LOAD_READY.
REQ-022 fwd_sel = k if matched entry ready, else 0; no match or s == 0 or source unused -> 0.
REQ-023 stall SHALL be 1 iff issue_valid and any used source matches a not-ready entry; combinational, same cycle as inputs.
REQ-024 While stall=1, fwd_sel outputs SHALL still reflect ready matches but are don't-care to consumers.
REQ-025 Load-use with LOAD_READY=2: exactly one stall cycle, then fwd_sel = 2.
REQ-026 flush SHALL clear all entry valid bits at the next edge and override the entry-1 load; stall and fwd_sel SHALL be 0 in the cycle after flush.
REQ-027 Simultaneous flush and stall: flush wins; no entry valid afterward.
REQ-028 Register 0 SHALL never be tracked, matched, stalled on or forwarded.
REQ-029 busy = OR of entry valid bits, combinational.

Reset
REQ-030 reset SHALL clear every entry valid bit on the next rising edge, regardless of other inputs.
REQ-031 After reset: stall=0, fwd_sel_a=0, fwd_sel_b=0, busy=0; reset mid-stall SHALL drop the stall the following cycle.

Configuration
REQ-032 Macro ID_SCOREBOARD_PERF_EN compiles in output stall_cycles (32 bits) and input perf_clear.
REQ-033 With ID_SCOREBOARD_PERF_EN: stall_cycles increments each cycle stall=1, saturates at 0xFFFFFFFF, clears on reset or perf_clear (clear wins over increment).
REQ-034 Without ID_SCOREBOARD_PERF_EN: ports and counter absent; all other behaviour identical.

Verification
REQ-035 Reset, then idle 4 cycles -> stall=0, fwd_sel_a=fwd_sel_b=0, busy=0 every cycle.
REQ-036 Issue ALU write r3, next cycle src_a=3 -> stall=0, fwd_sel_a=1; following cycle with src_a=3, no new write -> fwd_sel_a=2.
REQ-037 Issue load r5, next cycle src_b=5 -> stall=1 one cycle, then fwd_sel_b=2, stall=0; entry 1 empty during stall.
REQ-038 Writes to r7 at consecutive cycles, then src_a=7 -> fwd_sel_a=1 (youngest wins); write to r0 then src_a=0 -> fwd_sel_a=0, stall=0.
REQ-039 Load r4 issued, flush asserted with dependent src_a=4 in ID -> after edge stall=0, busy=0, fwd_sel_a=0.
REQ-040 With ID_SCOREBOARD_PERF_EN: 3 load-use stalls -> stall_cycles=3; perf_clear together with stall -> stall_cycles=0.
